bus_arbiter8: RTL and testbench
===============================

# bus_arbiter8

Round-robin arbiter that shares the processor's 8-input one-hot bus multiplexer among up to eight requesters. It samples a request vector each cycle and drives a registered one-hot grant that connects directly to the mux select. A hold limit stops any single requester from starving the others. It sits beside the bus mux in the datapath, and its grant vector is the mux's only select source.

## Interface
- MAXHOLD, default 4: maximum consecutive cycles an owner keeps the bus while any other request is pending; legal range 1..255.
- Clock  input  1  rising-edge clock; the only clock.
- Resetn  input  1  asynchronous, active-low reset.
- req  input  8  request vector; req[i] is held high while requester i wants the bus.
- grant  output  8  registered one-hot grant (or all zero); drives the mux select directly; bit i selects in_i.
- owner  output  3  binary index of the granted requester; 0 when idle.
- busy  output  1  registered; equals |grant.
- handoff  output  1  one-cycle pulse in the first cycle of any new grant (idle→owner or owner→different owner).

## Operation
- Reset (Resetn=0, asynchronous): grant=8'b0, owner=0, busy=0, handoff=0, pointer ptr=0, hold counter cnt=0, state=IDLE. No output changes while reset is asserted.
- Arbitration function pick(mask, start): returns the first index i in the order start, start+1, …, start+7 (mod 8) with mask[i]=1.
- IDLE:
  - If req=0, remain in IDLE and keep grant=0.
  - If req≠0, then k=pick(req, ptr). Next cycle: grant=1<<k, owner=k, cnt=1, handoff=1, ptr=(k+1) mod 8, state=OWN.
- OWN, current owner k. Let others = req & ~(1<<k).
  - Release (req[k]=0):
    - If others≠0: j=pick(others, k+1). Grant switches directly to j with no bubble cycle; cnt=1, handoff=1, ptr=j+1.
    - Otherwise: grant=0, owner=0, cnt=0, state=IDLE.
  - Preempt (req[k]=1, cnt=MAXHOLD, others≠0): j=pick(others, k+1). Grant switches to j; cnt=1, handoff=1, ptr=j+1.
  - Keep (in all other cases): grant is unchanged, handoff=0, and cnt increments, saturating at MAXHOLD.
- The grant is never more than one-hot. All-zero occurs only in IDLE.
- A requester that drops req and re-raises it competes from the current ptr like any other requester. It gets no priority memory.
- cnt is sized to $clog2(MAXHOLD+1) bits. It must never wrap.

## Timing
- All outputs are registered. They change only on a rising Clock edge or on assertion of Resetn.
- Grant latency is 1 cycle: a req sampled at edge n produces grant at edge n, visible in cycle n+1.
- Handoff is zero-bubble: on release or preempt, the new grant replaces the old one at the same edge.
- Under contention, an owner holds the bus for exactly MAXHOLD cycles. Without contention, it holds the bus indefinitely.
- While busy=0 the mux select is all-zero, so the mux output is X. Consumers must qualify bus data with busy.
- If Resetn deasserts while req is high, the first grant appears at the first rising edge after deassertion. Arbitration starts from ptr=0.
- If reset occurs mid-ownership, grant clears immediately. Pointer and counter history is lost.

## Test plan
- Reset behaviour: hold Resetn=0 with req=8'hFF. Require grant=0, busy=0, owner=0, handoff=0. Release reset: the next edge gives grant=8'h01, handoff=1.
- Single requester, MAXHOLD=4: req=8'h08 for 10 cycles, then 0. Require grant=8'h08 for all 10 cycles, handoff high only in the first cycle, then grant=0 one cycle after req falls.
- Round robin: req=8'h81 held. Require the grant sequence 8'h01 ×4, 8'h80 ×4, 8'h01 ×4, with a handoff pulse at each switch.
- Zero-bubble release: owner 2, req changes from 8'h24 to 8'h20. Require grant to move from 8'h04 to 8'h20 at the next edge, with busy never low.
- Pointer wrap: owner 6 releases with req=8'h41 then 8'h01 pending. Require next owner=0 (search wraps 7→0).
- Reset mid-ownership: assert Resetn low asynchronously between edges while grant=8'h10. Require grant=0 immediately. After release with req=8'h30, require grant=8'h10 (ptr=0 restarts the search at 0).

Source files
------------

// File: rtl/bus_arbiter8_if.sv
// Request/grant bundle between the bus requesters and the round-robin arbiter.
// The slave side is the arbiter; the master side is the requester population.
interface bus_arbiter8_if;
   logic [7:0] req;
   logic [7:0] grant;
   logic [2:0] owner;
   logic       busy;
   logic       handoff;

   modport slave  (input req, output grant, owner, busy, handoff);
   modport master (output req, input grant, owner, busy, handoff);
endinterface

// File: rtl/bus_arbiter8.sv
// Round-robin arbiter for the 8-input one-hot bus mux, with a hold limit
// so no owner keeps the bus beyond MAXHOLD cycles while others are waiting.
module bus_arbiter8 #(
   parameter int unsigned MAXHOLD = 4
) (
   input logic          Clock,
   input logic          Resetn,
   bus_arbiter8_if.slave bus
);
   localparam int unsigned   CW       = $clog2(MAXHOLD + 1);
   localparam logic [CW-1:0] HOLD_MAX = CW'(MAXHOLD);

   typedef enum logic {IDLE, OWN} state_t;

   state_t        state_q, state_d;
   logic [2:0]    ptr_q, ptr_d;
   logic [2:0]    owner_q, owner_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    grant_q, grant_d;
   logic          busy_q;
   logic          handoff_q, handoff_d;

   logic [7:0]    others;
   logic [3:0]    sel_idle, sel_next;

   // Returns {found, index} of the first set bit of mask, searching upward from start.
   function automatic logic [3:0] pick(input logic [7:0] mask, input logic [2:0] start);
      logic [3:0] r;
      logic [2:0] idx;
      r = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         idx = start + 3'(i);
         if (!r[3] && mask[idx]) r = {1'b1, idx};
      end
      return r;
   endfunction

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         owner_q   <= '0;
         cnt_q     <= '0;
         grant_q   <= '0;
         busy_q    <= 1'b0;
         handoff_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         owner_q   <= owner_d;
         cnt_q     <= cnt_d;
         grant_q   <= grant_d;
         busy_q    <= |grant_d;
         handoff_q <= handoff_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      owner_d   = owner_q;
      cnt_d     = cnt_q;
      grant_d   = grant_q;
      handoff_d = 1'b0;
      others    = bus.req & ~grant_q;
      sel_idle  = pick(bus.req, ptr_q);
      sel_next  = pick(others, owner_q + 3'd1);
      case (state_q)
         IDLE: begin
            if (sel_idle[3]) begin
               state_d   = OWN;
               owner_d   = sel_idle[2:0];
               grant_d   = 8'b1 << sel_idle[2:0];
               cnt_d     = CW'(1);
               handoff_d = 1'b1;
               ptr_d     = sel_idle[2:0] + 3'd1;
            end
         end
         OWN: begin
            // Release and preempt share the same zero-bubble switch to the next waiter.
            if ((!bus.req[owner_q] || cnt_q == HOLD_MAX) && sel_next[3]) begin
               owner_d   = sel_next[2:0];
               grant_d   = 8'b1 << sel_next[2:0];
               cnt_d     = CW'(1);
               handoff_d = 1'b1;
               ptr_d     = sel_next[2:0] + 3'd1;
            end else if (!bus.req[owner_q]) begin
               state_d = IDLE;
               owner_d = '0;
               grant_d = '0;
               cnt_d   = '0;
            end else if (cnt_q != HOLD_MAX) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.grant   = grant_q;
      bus.owner   = owner_q;
      bus.busy    = busy_q;
      bus.handoff = handoff_q;
   end
endmodule

// File: tb/tb_bus_arbiter8.sv
// Bench for bus_arbiter8: directed scenarios plus randomized traffic checked
// against a behavioural round-robin model.
module tb_bus_arbiter8;
   localparam int MAXHOLD = 4;

   logic Clock = 1'b0;
   logic Resetn = 1'b0;
   bus_arbiter8_if bus ();

   bus_arbiter8 #(.MAXHOLD(MAXHOLD)) dut (
      .Clock  (Clock),
      .Resetn (Resetn),
      .bus    (bus)
   );

   always #5 Clock = ~Clock;

   int n_vec = 0;
   int n_err = 0;

   // Behavioural model: owner index (-1 = idle), search pointer, cycles held.
   int m_owner = -1;
   int m_ptr = 0;
   int m_hold = 0;
   bit m_handoff = 0;

   function automatic int m_pick(logic [7:0] m, int s);
      for (int i = 0; i < 8; i++)
         if (m[(s + i) % 8]) return (s + i) % 8;
      return -1;
   endfunction

   task automatic model_reset();
      m_owner = -1; m_ptr = 0; m_hold = 0; m_handoff = 0;
   endtask

   task automatic model_step(logic [7:0] r);
      int j;
      logic [7:0] oth;
      m_handoff = 0;
      if (m_owner < 0) begin
         if (r != 0) begin
            j = m_pick(r, m_ptr);
            m_owner = j; m_hold = 1; m_handoff = 1; m_ptr = (j + 1) % 8;
         end
      end else begin
         oth = r;
         oth[m_owner] = 1'b0;
         if (!r[m_owner] || (m_hold == MAXHOLD && oth != 0)) begin
            if (oth != 0) begin
               j = m_pick(oth, (m_owner + 1) % 8);
               m_owner = j; m_hold = 1; m_handoff = 1; m_ptr = (j + 1) % 8;
            end else begin
               m_owner = -1; m_hold = 0;
            end
         end else if (m_hold < MAXHOLD) begin
            m_hold++;
         end
      end
   endtask

   function automatic logic [7:0] m_grant();
      return (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
   endfunction

   task automatic drive(logic [7:0] r);
      @(negedge Clock);
      bus.req = r;
   endtask

   task automatic cyc();
      @(posedge Clock);
      model_step(bus.req);
      #1;
   endtask

   task automatic do_reset();
      @(negedge Clock);
      Resetn = 1'b0;
      bus.req = 8'h00;
      model_reset();
      @(negedge Clock);
      Resetn = 1'b1;
   endtask

   task automatic test_reset();
      Resetn = 1'b0;
      bus.req = 8'hFF;
      model_reset();
      repeat (3) @(posedge Clock);
      #1;
      n_vec++; if (bus.grant !== 8'h00) begin n_err++; $display("FAIL reset_grant: got %h want 00", bus.grant); end
      n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      n_vec++; if (bus.owner !== 3'd0) begin n_err++; $display("FAIL reset_owner: got %0d want 0", bus.owner); end
      n_vec++; if (bus.handoff !== 1'b0) begin n_err++; $display("FAIL reset_handoff: got %b want 0", bus.handoff); end
      @(negedge Clock);
      Resetn = 1'b1;
      cyc();
      n_vec++; if (bus.grant !== 8'h01) begin n_err++; $display("FAIL reset_first_grant: got %h want 01", bus.grant); end
      n_vec++; if (bus.handoff !== 1'b1) begin n_err++; $display("FAIL reset_first_handoff: got %b want 1", bus.handoff); end
   endtask

   task automatic test_single();
      do_reset();
      for (int i = 0; i < 10; i++) begin
         drive(8'h08);
         cyc();
         n_vec++; if (bus.grant !== 8'h08) begin n_err++; $display("FAIL single_grant[%0d]: got %h want 08", i, bus.grant); end
         n_vec++; if (bus.handoff !== (i == 0)) begin n_err++; $display("FAIL single_handoff[%0d]: got %b want %b", i, bus.handoff, (i == 0)); end
         n_vec++; if (bus.owner !== 3'd3) begin n_err++; $display("FAIL single_owner[%0d]: got %0d want 3", i, bus.owner); end
      end
      drive(8'h00);
      cyc();
      n_vec++; if (bus.grant !== 8'h00) begin n_err++; $display("FAIL single_release: got %h want 00", bus.grant); end
      n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL single_busy_idle: got %b want 0", bus.busy); end
   endtask

   task automatic test_round_robin();
      logic [7:0] want;
      do_reset();
      drive(8'h81);
      for (int i = 0; i < 12; i++) begin
         cyc();
         want = ((i / 4) % 2 == 0) ? 8'h01 : 8'h80;
         n_vec++; if (bus.grant !== want) begin n_err++; $display("FAIL rr_grant[%0d]: got %h want %h", i, bus.grant, want); end
         n_vec++; if (bus.handoff !== (i % 4 == 0)) begin n_err++; $display("FAIL rr_handoff[%0d]: got %b want %b", i, bus.handoff, (i % 4 == 0)); end
      end
   endtask

   task automatic test_zero_bubble();
      do_reset();
      drive(8'h04); cyc();
      drive(8'h24); cyc();
      n_vec++; if (bus.grant !== 8'h04) begin n_err++; $display("FAIL zb_hold: got %h want 04", bus.grant); end
      n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL zb_busy0: got %b want 1", bus.busy); end
      drive(8'h20); cyc();
      n_vec++; if (bus.grant !== 8'h20) begin n_err++; $display("FAIL zb_switch: got %h want 20", bus.grant); end
      n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL zb_busy1: got %b want 1", bus.busy); end
      n_vec++; if (bus.handoff !== 1'b1) begin n_err++; $display("FAIL zb_handoff: got %b want 1", bus.handoff); end
   endtask

   task automatic test_pointer_wrap();
      do_reset();
      drive(8'h40); cyc();
      drive(8'h41); cyc();
      n_vec++; if (bus.owner !== 3'd6) begin n_err++; $display("FAIL wrap_owner6: got %0d want 6", bus.owner); end
      drive(8'h01); cyc();
      n_vec++; if (bus.owner !== 3'd0) begin n_err++; $display("FAIL wrap_owner0: got %0d want 0", bus.owner); end
      n_vec++; if (bus.grant !== 8'h01) begin n_err++; $display("FAIL wrap_grant: got %h want 01", bus.grant); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      drive(8'h10); cyc();
      n_vec++; if (bus.grant !== 8'h10) begin n_err++; $display("FAIL mid_pre: got %h want 10", bus.grant); end
      #2 Resetn = 1'b0;
      model_reset();
      #1;
      n_vec++; if (bus.grant !== 8'h00) begin n_err++; $display("FAIL mid_async_grant: got %h want 00", bus.grant); end
      n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL mid_async_busy: got %b want 0", bus.busy); end
      @(negedge Clock);
      bus.req = 8'h30;
      Resetn = 1'b1;
      cyc();
      n_vec++; if (bus.grant !== 8'h10) begin n_err++; $display("FAIL mid_restart: got %h want 10", bus.grant); end
   endtask

   task automatic test_random();
      logic [7:0] r;
      int roll;
      do_reset();
      r = 8'h00;
      for (int i = 0; i < 600; i++) begin
         roll = $urandom_range(0, 7);
         if (roll < 2) r = r ^ (8'h01 << $urandom_range(0, 7));
         else if (roll == 2) r = 8'($urandom_range(0, 255) & $urandom_range(0, 255));
         drive(r);
         if (i % 150 == 149) begin
            #2 Resetn = 1'b0;
            model_reset();
            #2 Resetn = 1'b1;
         end
         cyc();
         n_vec++; if (bus.grant !== m_grant()) begin n_err++; $display("FAIL rnd_grant[%0d]: req %h got %h want %h", i, r, bus.grant, m_grant()); end
         n_vec++; if (bus.owner !== 3'((m_owner < 0) ? 0 : m_owner)) begin n_err++; $display("FAIL rnd_owner[%0d]: got %0d want %0d", i, bus.owner, (m_owner < 0) ? 0 : m_owner); end
         n_vec++; if (bus.busy !== (m_owner >= 0)) begin n_err++; $display("FAIL rnd_busy[%0d]: got %b want %b", i, bus.busy, (m_owner >= 0)); end
         n_vec++; if (bus.handoff !== m_handoff) begin n_err++; $display("FAIL rnd_handoff[%0d]: got %b want %b", i, bus.handoff, m_handoff); end
      end
   endtask

   initial begin
      bus.req = 8'h00;
      test_reset();
      test_single();
      test_round_robin();
      test_zero_bubble();
      test_pointer_wrap();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
